// File: rtl/serial_borrow_subtractor_pkg.sv
// serial_borrow_subtractor_pkg
// Shared definitions for the bit-serial borrow subtractor: the control FSM
// state encoding and the default operand width used by the interface and top.
package serial_borrow_subtractor_pkg;

  // Default operand/difference width in bits (must be at least 2).
  localparam int DEFAULT_WIDTH = 4;

  // Control FSM states for the serial subtractor.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_borrow_subtractor_if.sv
// serial_borrow_subtractor_if
// Start/busy/done handshake plus operand and result bus of the serial
// subtractor.
//   start      request, sampled only while the subtractor is accepting
//   a, b, bin  minuend, subtrahend, borrow-in (captured on an accepted start)
//   busy       high while a subtraction is in progress
//   done       one-cycle completion pulse
//   diff, bout registered difference and borrow-out, held until next completion
// master drives the request side, slave is the subtractor itself.
interface serial_borrow_subtractor_if
  import serial_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell
// One-bit combinational full subtractor: computes x - y - bin.
//   x, y  operand bits
//   bin   borrow-in
//   d     difference bit
//   bout  borrow-out
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow is generated when x=0,y=1, and propagated when x==y.
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, processed LSB first
// through a single full-subtractor cell, one bit per clock. The borrow is
// carried between bits in a flop rather than a combinational ripple chain.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of the handshake/operand/result interface
// A start accepted at edge k gives busy after edge k through edge k+WIDTH and
// a one-cycle done pulse after edge k+WIDTH. diff/bout only change on done.
module serial_borrow_subtractor
  import serial_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_borrow_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             br;
  logic [CNT_W-1:0] count;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             cell_d;
  logic             cell_bout;

  // The single arithmetic cell always works on the current LSBs and the
  // borrow carried over from the previous bit.
  full_subtractor_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Difference bits enter from the MSB side, so after WIDTH shifts bit 0 of
  // the result has landed at position 0.
  assign res_next = {cell_d, res_sh[WIDTH-1:1]};

  // Control FSM, bit counter, operand/result shift registers and the
  // registered outputs. IDLE and DONE both accept a new start, which is what
  // lets a held start run back-to-back operations without an IDLE gap. The
  // final bit writes diff/bout straight from res_next and the cell's borrow so
  // they are valid in the same cycle done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= bus.bin;
            res_sh <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res_sh <= res_next;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          br     <= cell_bout;
          count  <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            diff_q <= res_next;
            bout_q <= cell_bout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule
